// File: rtl/gf13_pkg.sv
// gf13_pkg: shared definitions for GF(2^13) arithmetic blocks.
//   M      : field degree
//   ORDER  : multiplicative group order (2^13 - 1)
//   POLY   : low M bits of x^13+x^4+x^3+x+1 (x^13 term implicit)
//   ONE    : multiplicative identity in PB representation
//   gf13_t : field element / exponent container
//   state_t: discrete-log FSM states
// Build option: DLOG_BIDIR_EN selects the two-cursor search length.
package gf13_pkg;

    localparam int M     = 13;
    localparam int ORDER = 8191;

    typedef logic [M-1:0] gf13_t;

    localparam gf13_t POLY = 13'h001B;
    localparam gf13_t ONE  = 13'h0001;

    typedef enum logic {
        IDLE,
        SEARCH
    } state_t;

    // Final step index of the search. Two cursors cover the group from both
    // ends, so only half the exponents need to be visited.
`ifdef DLOG_BIDIR_EN
    localparam gf13_t LAST_STEP = 13'd4095;
`else
    localparam gf13_t LAST_STEP = 13'd8190;
`endif

endpackage

// File: rtl/gf_alpha_step.sv
// gf_alpha_step: combinational multiply of a PB element by alpha (DIR=0)
// or by alpha^-1 (DIR=1) in GF(2^13).
//   x : input element
//   y : x * alpha^(+1 or -1)
// Shared by the discrete-log search and the Chien search.
module gf_alpha_step
    import gf13_pkg::*;
#(
    parameter bit    DIR       = 1'b0,
    parameter gf13_t STEP_POLY = POLY
) (
    input  gf13_t x,
    output gf13_t y
);

    generate
        if (DIR == 1'b0) begin : g_up
            // Shift up; an overflowing x^13 term folds back as POLY.
            assign y = {x[M-2:0], 1'b0} ^ (x[M-1] ? STEP_POLY : '0);
        end else begin : g_down
            // If x has an x^0 term, add the full polynomial (including the
            // implicit x^13) so the value becomes divisible by x, then shift.
            gf13_t folded;
            assign folded = x[0] ? (x ^ STEP_POLY) : x;
            assign y      = {x[0], folded[M-1:1]};
        end
    endgenerate

endmodule

// File: rtl/gf_discrete_log.sv
// gf_discrete_log: discrete logarithm in GF(2^13) by sequential search.
// A cursor walks alpha^0, alpha^1, ... one step per clock until it equals
// the captured element; the step count is the logarithm.
//
// Ports:
//   clk   : clock, all state changes on posedge
//   rst_n : asynchronous active-low reset
//   b     : element to take the log of, sampled when start is accepted
//   start : request, accepted only when idle
//   a     : logarithm of b (0..8190), held until next accepted start
//   err   : b was zero or search exhausted, held with a
//   done  : one-cycle pulse, a/err valid
//   busy  : high from start acceptance until the edge that raises done
//
// Build option: DLOG_BIDIR_EN adds a second cursor walking by alpha^-1,
// halving worst-case latency with identical results.
module gf_discrete_log
    import gf13_pkg::*;
#(
    parameter int    M    = gf13_pkg::M,
    parameter gf13_t POLY = gf13_pkg::POLY
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [M-1:0] b,
    input  logic         start,
    output logic [M-1:0] a,
    output logic         err,
    output logic         done,
    output logic         busy
);

    state_t state, state_n;
    gf13_t  b_q, b_n;
    gf13_t  cur, cur_n, cur_up;
    gf13_t  k, k_n;
    gf13_t  a_n;
    logic   err_n, done_n, busy_n;

    gf_alpha_step #(.DIR(1'b0), .STEP_POLY(POLY)) u_step_up (
        .x (cur),
        .y (cur_up)
    );

`ifdef DLOG_BIDIR_EN
    gf13_t dcur, dcur_n, dcur_down;

    gf_alpha_step #(.DIR(1'b1), .STEP_POLY(POLY)) u_step_down (
        .x (dcur),
        .y (dcur_down)
    );
`endif

    always_comb begin
        // NOTE: every signal assigned here gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        state_n = state;
        b_n     = b_q;
        cur_n   = cur;
        k_n     = k;
        a_n     = a;
        err_n   = err;
        done_n  = 1'b0;
        busy_n  = busy;
`ifdef DLOG_BIDIR_EN
        dcur_n  = dcur;
`endif

        unique case (state)
            IDLE: begin
                if (start) begin
                    b_n     = b;
                    cur_n   = ONE;
                    k_n     = '0;
                    busy_n  = 1'b1;
                    state_n = SEARCH;
`ifdef DLOG_BIDIR_EN
                    dcur_n  = ONE;
`endif
                end
            end

            SEARCH: begin
                if (b_q == '0) begin
                    // Zero has no logarithm.
                    a_n     = '0;
                    err_n   = 1'b1;
                    done_n  = 1'b1;
                    busy_n  = 1'b0;
                    state_n = IDLE;
                end else if (cur == b_q) begin
                    a_n     = k;
                    err_n   = 1'b0;
                    done_n  = 1'b1;
                    busy_n  = 1'b0;
                    state_n = IDLE;
`ifdef DLOG_BIDIR_EN
                end else if (dcur == b_q) begin
                    // dcur = alpha^-k = alpha^(ORDER-k); k=0 never gets here
                    // because the up cursor matches first.
                    a_n     = gf13_t'(ORDER) - k;
                    err_n   = 1'b0;
                    done_n  = 1'b1;
                    busy_n  = 1'b0;
                    state_n = IDLE;
`endif
                end else if (k == LAST_STEP) begin
                    // Only reachable with a non-primitive polynomial.
                    a_n     = '0;
                    err_n   = 1'b1;
                    done_n  = 1'b1;
                    busy_n  = 1'b0;
                    state_n = IDLE;
                end else begin
                    cur_n   = cur_up;
                    k_n     = k + 1'b1;
`ifdef DLOG_BIDIR_EN
                    dcur_n  = dcur_down;
`endif
                end
            end

            default: state_n = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            b_q   <= '0;
            cur   <= ONE;
            k     <= '0;
            a     <= '0;
            err   <= 1'b0;
            done  <= 1'b0;
            busy  <= 1'b0;
        end else begin
            state <= state_n;
            b_q   <= b_n;
            cur   <= cur_n;
            k     <= k_n;
            a     <= a_n;
            err   <= err_n;
            done  <= done_n;
            busy  <= busy_n;
        end
    end

`ifdef DLOG_BIDIR_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dcur <= ONE;
        end else begin
            dcur <= dcur_n;
        end
    end
`endif

endmodule

// File: tb/tb_gf_discrete_log.sv
// tb_gf_discrete_log: directed self-checking bench for gf_discrete_log.
// Checks reset values, results, done latency, single-cycle done, start
// ignored while busy, back-to-back start, zero input and reset mid-search.
// Expected latency follows DLOG_BIDIR_EN when the bench is built with it.
module tb_gf_discrete_log;

    logic        clk;
    logic        rst_n;
    logic [12:0] b;
    logic        start;
    logic [12:0] a;
    logic        err;
    logic        done;
    logic        busy;

    int tests_run;
    int tests_failed;

    gf_discrete_log dut (
        .clk   (clk),
        .rst_n (rst_n),
        .b     (b),
        .start (start),
        .a     (a),
        .err   (err),
        .done  (done),
        .busy  (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    // alpha^n by repeated doubling modulo x^13+x^4+x^3+x+1.
    function automatic logic [12:0] alpha_pow(input int n);
        logic [13:0] y;
        y = 14'd1;
        for (int i = 0; i < n; i++) begin
            y = y << 1;
            if (y[13]) y = y ^ 14'h201B;
        end
        return y[12:0];
    endfunction

    // Edges from the accepting edge to the edge that raises done.
    function automatic int exp_latency(input int av, input bit is_zero);
        if (is_zero) return 1;
`ifdef DLOG_BIDIR_EN
        if (av > 4095) return 8192 - av;
`endif
        return av + 1;
    endfunction

    // Issue one request and check result and latency. Called just after a
    // posedge. If poke is set, a stray start with a different b is driven
    // mid-search. Returns with done high (just after the done edge).
    task automatic run(input string tag, input logic [12:0] bv, input int exp_a,
                       input bit exp_err, input bit poke);
        int cycles;
        b     = bv;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        b     = 13'h1ABC;
        check({tag, ".busy_after_start"}, busy, 1);
        cycles = 0;
        while (!done && cycles < 9000) begin
            if (poke && cycles == 2) begin
                start = 1'b1;
                b     = 13'h0002;
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            cycles++;
            #1;
        end
        start = 1'b0;
        check({tag, ".done_seen"}, done, 1);
        check({tag, ".a"}, a, exp_a);
        check({tag, ".err"}, err, exp_err);
        check({tag, ".latency"}, cycles, exp_latency(exp_a, bv == 13'h0));
        check({tag, ".busy_at_done"}, busy, 0);
    endtask

    task automatic check_pulse_end(input string tag, input logic [12:0] exp_a, input bit exp_err);
        @(posedge clk);
        #1;
        check({tag, ".done_single"}, done, 0);
        check({tag, ".a_held"}, a, exp_a);
        check({tag, ".err_held"}, err, exp_err);
    endtask

    initial begin
        int sweep_a [8];
        int pulses;
        sweep_a = '{2, 12, 100, 1000, 4095, 4096, 5000, 7000};
        tests_run    = 0;
        tests_failed = 0;
        b     = '0;
        start = 1'b0;
        rst_n = 1'b0;
        #12;
        check("reset.a", a, 0);
        check("reset.err", err, 0);
        check("reset.done", done, 0);
        check("reset.busy", busy, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Hand-computed vectors.
        run("one", 13'h0001, 0, 0, 0);
        check_pulse_end("one", 13'd0, 0);
        run("alpha", 13'h0002, 1, 0, 0);
        check_pulse_end("alpha", 13'd1, 0);
        run("zero", 13'h0000, 0, 1, 0);
        check_pulse_end("zero", 13'd0, 1);
        run("alpha13", 13'h001B, 13, 0, 0);
        check_pulse_end("alpha13", 13'd13, 0);
        run("alpha_inv", 13'h100D, 8190, 0, 0);
        check_pulse_end("alpha_inv", 13'd8190, 0);

        // Back-to-back: start driven while done is high.
        run("b2b_first", 13'h0004, 2, 0, 0);
        run("b2b_second", 13'h0008, 3, 0, 0);
        check_pulse_end("b2b_second", 13'd3, 0);

        // Stray start while busy must not disturb the search.
        run("busy_start", alpha_pow(100), 100, 0, 1);
        check_pulse_end("busy_start", 13'd100, 0);

        // Elements generated from known exponents.
        foreach (sweep_a[i]) begin
            run($sformatf("sweep%0d", sweep_a[i]), alpha_pow(sweep_a[i]), sweep_a[i], 0, 0);
            check_pulse_end($sformatf("sweep%0d", sweep_a[i]), 13'(sweep_a[i]), 0);
        end

        // Reset mid-search aborts without a done pulse.
        b     = alpha_pow(300);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midreset.busy", busy, 0);
        check("midreset.a", a, 0);
        check("midreset.done", done, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < 400; i++) begin
            @(posedge clk);
            #1;
            if (done) pulses++;
        end
        check("midreset.no_done", pulses, 0);
        run("after_reset", 13'h0010, 4, 0, 0);
        check_pulse_end("after_reset", 13'd4, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
